// File: rtl/stack_eval_pkg.sv
// stack_eval_pkg: shared states, op codes, flag/error bit positions for the postfix sequencer
package stack_eval_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_POP_B, S_POP_A, S_EXEC, S_PUSH_RES, S_FINAL, S_ERR
    } state_t;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_END = 3'b111;
    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_END = 2;
    function automatic int flag_bit(input int w);
        return w - 1;
    endfunction
endpackage

// File: rtl/stack_depth_ctr.sv
// stack_depth_ctr: tracks external stack occupancy and flags full / at-least-two / exactly-one
module stack_depth_ctr #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full,
    output logic ge2,
    output logic eq1
);
    localparam int DW = $clog2(DEPTH + 1);
    logic [DW-1:0] depth_q, depth_d;
    always_comb depth_d = clr ? '0 : inc ? depth_q + 1'b1 : dec ? depth_q - 1'b1 : depth_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) depth_q <= '0;
        else      depth_q <= depth_d;
    assign full = depth_q == DW'(DEPTH);
    assign ge2  = depth_q >= DW'(2);
    assign eq1  = depth_q == DW'(1);
endmodule

// File: rtl/stack_eval_sequencer.sv
// stack_eval_sequencer: expands postfix tokens into stack/ALU micro-steps and returns the final value
module stack_eval_sequencer
    import stack_eval_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              tok_valid,
    input  logic [DATA_W-1:0] tok_data,
    output logic              tok_ready,
    output logic              stk_push,
    output logic              stk_wsel,
    output logic              stk_pop,
    output logic              stk_clr,
    input  logic [DATA_W-1:0] stk_rdata,
    output logic              alu_b_ld,
    output logic              alu_a_ld,
    output logic [2:0]        alu_op,
    output logic              alu_go,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic [2:0]        err
);
    localparam int LW   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam int FLAG = flag_bit(DATA_W);
    state_t state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [2:0] op_q, op_d, err_q, err_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic d_inc, d_dec, d_clr, full, ge2, eq1;
    wire [2:0] code = tok_data[2:0];
    stack_depth_ctr #(.DEPTH(DEPTH)) u_depth (
        .clk(clk), .rst(rst), .inc(d_inc), .dec(d_dec), .clr(d_clr),
        .full(full), .ge2(ge2), .eq1(eq1)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q  <= S_IDLE;
            lat_q    <= '0;
            op_q     <= '0;
            err_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            op_q     <= op_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    always_comb begin
        state_d = state_q;
        lat_d = lat_q;
        op_d = op_q;
        err_d = err_q;
        result_d = result_q;
        tok_ready = 1'b0;
        stk_push = 1'b0;
        stk_wsel = 1'b0;
        stk_pop = 1'b0;
        stk_clr = 1'b0;
        alu_b_ld = 1'b0;
        alu_a_ld = 1'b0;
        alu_go = 1'b0;
        result_valid = 1'b0;
        d_inc = 1'b0;
        d_dec = 1'b0;
        d_clr = 1'b0;
        case (state_q)
            S_IDLE, S_ERR: if (start) begin
                stk_clr = 1'b1;
                d_clr = 1'b1;
                err_d = '0;
                result_d = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                tok_ready = 1'b1;
                if (tok_valid) begin
                    if (!tok_data[FLAG]) begin
                        stk_push = !full;
                        d_inc = !full;
                        err_d[ERR_OVF] = full;
                        state_d = full ? S_ERR : S_FETCH;
                    end else if (code == OP_END) begin
                        err_d[ERR_END] = !eq1;
                        state_d = eq1 ? S_FINAL : S_ERR;
                    end else begin
                        op_d = ge2 ? code : op_q;
                        err_d[ERR_UNF] = !ge2;
                        state_d = ge2 ? S_POP_B : S_ERR;
                    end
                end
            end
            S_POP_B: begin
                stk_pop = 1'b1;
                alu_b_ld = 1'b1;
                d_dec = 1'b1;
                state_d = S_POP_A;
            end
            S_POP_A: begin
                stk_pop = 1'b1;
                alu_a_ld = 1'b1;
                d_dec = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_go = lat_q == '0;
                lat_d = (lat_q == LW'(ALU_LAT - 1)) ? '0 : lat_q + 1'b1;
                state_d = (lat_q == LW'(ALU_LAT - 1)) ? S_PUSH_RES : S_EXEC;
            end
            S_PUSH_RES: begin
                stk_push = 1'b1;
                stk_wsel = 1'b1;
                d_inc = 1'b1;
                state_d = S_FETCH;
            end
            S_FINAL: begin
                stk_pop = 1'b1;
                result_valid = 1'b1;
                result_d = stk_rdata;
                d_clr = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // the final value is forwarded during its valid pulse, then held in result_q
    assign result = (state_q == S_FINAL) ? stk_rdata : result_q;
    assign alu_op = op_q;
    assign err    = err_q;
    assign busy   = (state_q != S_IDLE) && (state_q != S_ERR);
endmodule
